// File: rtl/eab_pipe.sv
// Two-stage pipelined LC3 effective-address block (base mux, offset mux, adder) with
// valid/ready handshakes, tag sideband and flush. Define EAB_PIPE_FLAGS_EN for carry/overflow flags.
module eab_pipe #(
    parameter int DATA_W = 16,
    parameter int IR_W   = 11,
    parameter int OFF1_W = 6,
    parameter int OFF2_W = 9,
    parameter int OFF3_W = 11,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] ra,
    input  logic              sel_eab1,
    input  logic [1:0]        sel_eab2,
    input  logic [IR_W-1:0]   ir,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] eab_out,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_carry,
    output logic              out_ovf
);

    // Sign-extend the low w bits of a zero-extended field to the full word.
    function automatic logic [DATA_W-1:0] sext(input logic [DATA_W-1:0] raw, input int unsigned w);
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] msb_word;
        mask     = {DATA_W{1'b1}} << w;
        msb_word = raw >> (w - 32'd1);
        return msb_word[0] ? (raw | mask) : (raw & ~mask);
    endfunction

    logic              s1_valid_r;
    logic [DATA_W-1:0] s1_base_r;
    logic [DATA_W-1:0] s1_off_r;
    logic [TAG_W-1:0]  s1_tag_r;
    logic              s2_valid_r;
    logic [DATA_W-1:0] s2_sum_r;
    logic [TAG_W-1:0]  s2_tag_r;
    logic              s2_carry_r;
    logic              s2_ovf_r;

    logic              s2_free_s;
    logic              s1_adv_s;
    logic              accept_s;
    logic [DATA_W-1:0] base_s;
    logic [DATA_W-1:0] off_s;
    logic [DATA_W-1:0] sum_s;
    logic              carry_s;
    logic              ovf_s;

    // s2 can take a new entry when empty or when its current result leaves this cycle
    assign s2_free_s = !s2_valid_r | out_ready;
    assign s1_adv_s  = s1_valid_r & s2_free_s;
    assign in_ready  = !flush & (!s1_valid_r | s1_adv_s);
    assign accept_s  = in_valid & in_ready;
    assign base_s    = sel_eab1 ? ra : pc;

    // Offset field selection with sign extension.
    always_comb begin
        off_s = {DATA_W{1'b0}};
        case (sel_eab2)
            2'd0:    off_s = {DATA_W{1'b0}};
            2'd1:    off_s = sext(DATA_W'(ir[OFF1_W-1:0]), OFF1_W);
            2'd2:    off_s = sext(DATA_W'(ir[OFF2_W-1:0]), OFF2_W);
            2'd3:    off_s = sext(DATA_W'(ir[OFF3_W-1:0]), OFF3_W);
            default: off_s = {DATA_W{1'b0}};
        endcase
    end

`ifdef EAB_PIPE_FLAGS_EN
    logic [DATA_W:0] wide_s;
    assign wide_s  = {1'b0, s1_base_r} + {1'b0, s1_off_r};
    assign sum_s   = wide_s[DATA_W-1:0];
    assign carry_s = wide_s[DATA_W];
    assign ovf_s   = (s1_base_r[DATA_W-1] == s1_off_r[DATA_W-1]) &
                     (wide_s[DATA_W-1] != s1_base_r[DATA_W-1]);
`else
    assign sum_s   = s1_base_r + s1_off_r;
    assign carry_s = 1'b0;
    assign ovf_s   = 1'b0;
`endif

    // Stage 1: capture operands and tag on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_base_r  <= {DATA_W{1'b0}};
            s1_off_r   <= {DATA_W{1'b0}};
            s1_tag_r   <= {TAG_W{1'b0}};
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_base_r  <= base_s;
            s1_off_r   <= off_s;
            s1_tag_r   <= in_tag;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: register the sum and flags; hold everything while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r <= 1'b0;
            s2_sum_r   <= {DATA_W{1'b0}};
            s2_tag_r   <= {TAG_W{1'b0}};
            s2_carry_r <= 1'b0;
            s2_ovf_r   <= 1'b0;
        end else if (flush) begin
            s2_valid_r <= 1'b0;
        end else if (s2_free_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sum_r   <= sum_s;
                s2_tag_r   <= s1_tag_r;
                s2_carry_r <= carry_s;
                s2_ovf_r   <= ovf_s;
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign eab_out   = s2_sum_r;
    assign out_tag   = s2_tag_r;
    assign out_carry = s2_carry_r;
    assign out_ovf   = s2_ovf_r;

endmodule

// File: tb/tb_eab_pipe.sv
// Directed table-driven bench for eab_pipe: single-issue and streamed vectors, then
// backpressure, flush and mid-stall reset sequences.
module tb_eab_pipe;

`ifdef EAB_PIPE_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pc;
    logic [15:0] ra;
    logic        sel_eab1;
    logic [1:0]  sel_eab2;
    logic [10:0] ir;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] eab_out;
    logic [3:0]  out_tag;
    logic        out_carry;
    logic        out_ovf;

    eab_pipe dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .ra(ra), .sel_eab1(sel_eab1), .sel_eab2(sel_eab2),
        .ir(ir), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .eab_out(eab_out), .out_tag(out_tag),
        .out_carry(out_carry), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ra;
        logic        sel1;
        logic [1:0]  sel2;
        logic [10:0] ir;
        logic [3:0]  tag;
        logic [15:0] eab;
        logic        carry;
        logic        ovf;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];
    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pc = v.pc; ra = v.ra; sel_eab1 = v.sel1; sel_eab2 = v.sel2; ir = v.ir; in_tag = v.tag;
    endtask

    task automatic drive_simple(input logic [3:0] t);
        pc = {4'h0, t, 8'h00}; ra = 16'hDEAD; sel_eab1 = 1'b0; sel_eab2 = 2'd0;
        ir = 11'h7FF; in_tag = t;
    endtask

    function automatic logic [31:0] expv(input vec_t v);
        return {9'd0, 1'b1, v.tag, v.carry & FLAGS_ON, v.ovf & FLAGS_ON, v.eab};
    endfunction

    function automatic logic [31:0] actv();
        return {9'd0, out_valid, out_tag, out_carry, out_ovf, eab_out};
    endfunction

    function automatic logic [31:0] exps(input logic [3:0] t);
        return {11'd0, 1'b1, t, 4'h0, t, 8'h00};
    endfunction

    function automatic logic [31:0] acts();
        return {11'd0, out_valid, out_tag, eab_out};
    endfunction

    initial begin
        int cnt;
        vt[0]  = '{16'h3000, 16'h1234, 1'b0, 2'd2, 11'h1FF, 4'h1, 16'h2FFF, 1'b1, 1'b0};
        vt[1]  = '{16'h1111, 16'h4000, 1'b1, 2'd1, 11'h020, 4'h5, 16'h3FE0, 1'b1, 1'b0};
        vt[2]  = '{16'h1111, 16'h4000, 1'b1, 2'd0, 11'h7FF, 4'h6, 16'h4000, 1'b0, 1'b0};
        vt[3]  = '{16'h3000, 16'h5555, 1'b0, 2'd3, 11'h400, 4'h7, 16'h2C00, 1'b1, 1'b0};
        vt[4]  = '{16'h3000, 16'h5555, 1'b0, 2'd3, 11'h3FF, 4'h8, 16'h33FF, 1'b0, 1'b0};
        vt[5]  = '{16'h0000, 16'h7FFF, 1'b1, 2'd1, 11'h001, 4'h9, 16'h8000, 1'b0, 1'b1};
        vt[6]  = '{16'h0000, 16'hFFFF, 1'b1, 2'd1, 11'h03F, 4'hA, 16'hFFFE, 1'b1, 1'b0};
        vt[7]  = '{16'h1000, 16'h2222, 1'b0, 2'd1, 11'h7C5, 4'hB, 16'h1005, 1'b0, 1'b0};
        vt[8]  = '{16'h8000, 16'h0001, 1'b0, 2'd2, 11'h6FF, 4'hC, 16'h80FF, 1'b0, 1'b0};
        vt[9]  = '{16'h0002, 16'h8000, 1'b1, 2'd3, 11'h400, 4'hD, 16'h7C00, 1'b1, 1'b1};
        vt[10] = '{16'h0100, 16'h3333, 1'b0, 2'd2, 11'h100, 4'hE, 16'h0000, 1'b1, 1'b0};

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive_simple(4'h0);
        #12;
        chk("reset_outputs", actv(), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // single issue: one request, check latency, then result
        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            in_valid = 1'b1;
            chk("single_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            chk("single_latency", {31'd0, out_valid}, 32'd0);
            tick();
            chk($sformatf("single_vec%0d", i), actv(), expv(vt[i]));
        end
        tick();

        // streamed back-to-back: one result per clock
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                drive(vt[i]);
                in_valid = 1'b1;
                chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1) chk($sformatf("stream_vec%0d", i - 1), actv(), expv(vt[i - 1]));
        end
        tick();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // backpressure: two fit, third waits, order preserved on release
        out_ready = 1'b0;
        drive_simple(4'h1); in_valid = 1'b1;
        chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        drive_simple(4'h2);
        chk("bp_rdy2", {31'd0, in_ready}, 32'd1);
        tick();
        drive_simple(4'h3);
        chk("bp_rdy3_blocked", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        chk("bp_hold", acts(), exps(4'h1));
        chk("bp_still_blocked", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out2", acts(), exps(4'h2));
        tick();
        chk("bp_out3", acts(), exps(4'h3));
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // flush with two in flight and a dropped request
        out_ready = 1'b0;
        drive_simple(4'h4); in_valid = 1'b1;
        tick();
        drive_simple(4'h5);
        tick();
        chk("fl_two_in_flight", acts(), exps(4'h4));
        drive_simple(4'h6);
        flush = 1'b1;
        #1;
        chk("fl_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_valid_cleared", {31'd0, out_valid}, 32'd0);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("fl_nothing_emitted", cnt, 32'd0);

        // asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        drive_simple(4'h8); in_valid = 1'b1;
        tick();
        drive_simple(4'h9);
        tick();
        in_valid = 1'b0;
        chk("rst_pre_stall", acts(), exps(4'h8));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_outputs", actv(), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("rst_no_stale", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
